// File: rtl/regfile_write_arbiter_if.sv
// Writeback bundle between the ALU/load requesters and the register-file write arbiter.
// master drives requests and the counter clear; slave arbitrates and owns the write port.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_destination;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_destination;
    logic [DATA_WIDTH-1:0] mem_data;

    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_destination;
    logic [DATA_WIDTH-1:0] write_data;

    logic                  count_clear;
    logic [CNT_WIDTH-1:0]  alu_stall_count;

    modport master (
        output alu_valid, alu_destination, alu_data,
        output mem_valid, mem_destination, mem_data,
        output count_clear,
        input  alu_ready, mem_ready,
        input  write_enable, write_destination, write_data,
        input  alu_stall_count
    );

    modport slave (
        input  alu_valid, alu_destination, alu_data,
        input  mem_valid, mem_destination, mem_data,
        input  count_clear,
        output alu_ready, mem_ready,
        output write_enable, write_destination, write_data,
        output alu_stall_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writeback.
// Loads win by default; an ALU request denied STARVE_LIMIT cycles in a row wins next.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0]   starve_cnt;
    logic                  alu_prio;
    logic                  mem_grant;
    logic                  alu_grant;
    logic                  alu_stalled;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_dest;
    logic [DATA_WIDTH-1:0] sel_data;

    // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        alu_prio    = bus.alu_valid && (starve_cnt == STARVE_MAX);
        mem_grant   = bus.mem_valid && !alu_prio;
        alu_grant   = bus.alu_valid && !mem_grant;
        alu_stalled = bus.alu_valid && !alu_grant;
        sel_dest    = mem_grant ? bus.mem_destination : bus.alu_destination;
        sel_data    = mem_grant ? bus.mem_data        : bus.alu_data;
        // x0 requests are consumed here but never strobe the register file
        sel_write   = (mem_grant || alu_grant) && (sel_dest != '0);
    end

    assign bus.mem_ready = mem_grant;
    assign bus.alu_ready = alu_grant;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (alu_stalled) begin
            if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // NOTE: destination/data are reset too, so the write port reads 0 until the first real write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.write_enable      <= 1'b0;
            bus.write_destination <= '0;
            bus.write_data        <= '0;
        end else begin
            bus.write_enable <= sel_write;
            if (sel_write) begin
                bus.write_destination <= sel_dest;
                bus.write_data        <= sel_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.alu_stall_count <= '0;
        end else if (bus.count_clear) begin
            bus.alu_stall_count <= '0;
        end else if (alu_stalled && (bus.alu_stall_count != '1)) begin
            bus.alu_stall_count <= bus.alu_stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter against a queue-based grant model.
// A second instance with a 4-bit stall counter exercises counter saturation cheaply.
module tb_regfile_write_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 3;
    localparam int CW    = 16;
    localparam int SCW   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW))  bus ();
    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(SCW)) sbus ();

    regfile_write_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    regfile_write_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(SCW)
    ) dut_small (
        .clock (clock),
        .reset (reset),
        .bus   (sbus.slave)
    );

    assign sbus.alu_valid       = bus.alu_valid;
    assign sbus.alu_destination = bus.alu_destination;
    assign sbus.alu_data        = bus.alu_data;
    assign sbus.mem_valid       = bus.mem_valid;
    assign sbus.mem_destination = bus.mem_destination;
    assign sbus.mem_data        = bus.mem_data;
    assign sbus.count_clear     = bus.count_clear;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wr_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int            alu_denials;
    int            stall_ref;
    int            small_ref;
    wr_t           pend_q[$];
    logic [AW-1:0] held_dest;
    logic [DW-1:0] held_data;
    int            n_exp_writes;
    int            n_dut_writes;
    logic          obs_mem;
    logic          obs_alu;
    logic          alu_took;
    logic          mem_took;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        alu_denials  = 0;
        stall_ref    = 0;
        small_ref    = 0;
        pend_q.delete();
        held_dest    = '0;
        held_data    = '0;
        n_exp_writes = 0;
        n_dut_writes = 0;
    endtask

    task automatic idle_inputs();
        bus.alu_valid       = 1'b0;
        bus.alu_destination = '0;
        bus.alu_data        = '0;
        bus.mem_valid       = 1'b0;
        bus.mem_destination = '0;
        bus.mem_data        = '0;
        bus.count_clear     = 1'b0;
    endtask

    // One clock cycle: check at the falling edge, advance the model, return 1 time unit after rise.
    task automatic step();
        logic exp_mem;
        logic exp_alu;
        wr_t  w;
        @(negedge clock);
        exp_mem = bus.mem_valid && !(bus.alu_valid && alu_denials >= LIMIT);
        exp_alu = bus.alu_valid && !exp_mem;
        obs_mem = bus.mem_ready;
        obs_alu = bus.alu_ready;
        check("mem_ready", 64'(bus.mem_ready), 64'(exp_mem));
        check("alu_ready", 64'(bus.alu_ready), 64'(exp_alu));

        if (bus.write_enable === 1'b1) n_dut_writes++;
        if (pend_q.size() > 0) begin
            w = pend_q.pop_front();
            held_dest = w.dest;
            held_data = w.data;
            check("write_enable", 64'(bus.write_enable), 64'(1));
        end else begin
            check("write_enable", 64'(bus.write_enable), 64'(0));
        end
        check("write_destination", 64'(bus.write_destination), 64'(held_dest));
        check("write_data", 64'(bus.write_data), 64'(held_data));
        check("alu_stall_count", 64'(bus.alu_stall_count), 64'(stall_ref));
        check("alu_stall_count_small", 64'(sbus.alu_stall_count), 64'(small_ref));

        if (exp_mem && bus.mem_destination != '0) begin
            pend_q.push_back(wr_t'({bus.mem_destination, bus.mem_data}));
            n_exp_writes++;
        end else if (exp_alu && bus.alu_destination != '0) begin
            pend_q.push_back(wr_t'({bus.alu_destination, bus.alu_data}));
            n_exp_writes++;
        end

        if (bus.count_clear) begin
            stall_ref = 0;
            small_ref = 0;
        end else if (bus.alu_valid && !exp_alu) begin
            stall_ref = (stall_ref + 1 > 65535) ? 65535 : stall_ref + 1;
            small_ref = (small_ref + 1 > 15) ? 15 : small_ref + 1;
        end
        alu_denials = (bus.alu_valid && !exp_alu) ? alu_denials + 1 : 0;
        alu_took    = exp_alu;
        mem_took    = exp_mem;

        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        model_reset();

        // Reset state
        #12;
        check("reset_write_enable", 64'(bus.write_enable), 64'(0));
        check("reset_write_destination", 64'(bus.write_destination), 64'(0));
        check("reset_write_data", 64'(bus.write_data), 64'(0));
        check("reset_stall_count", 64'(bus.alu_stall_count), 64'(0));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // 1: lone ALU request is accepted at once and written next cycle
        bus.alu_valid       = 1'b1;
        bus.alu_destination = 5'd5;
        bus.alu_data        = 32'hDEADBEEF;
        step();
        check("t1_alu_ready", 64'(obs_alu), 64'(1));
        idle_inputs();
        step();

        // 2: both valid continuously -> M M M A M M M A
        bus.alu_valid       = 1'b1;
        bus.alu_destination = 5'd9;
        bus.alu_data        = 32'hA1A1A1A1;
        bus.mem_valid       = 1'b1;
        bus.mem_destination = 5'd7;
        for (int i = 0; i < 8; i++) begin
            bus.mem_data = 32'h1000 + 32'(i);
            step();
            check("t2_mem_grant", 64'(obs_mem), 64'((i % 4) != 3));
            check("t2_alu_grant", 64'(obs_alu), 64'((i % 4) == 3));
        end
        idle_inputs();
        step();

        // 3: load to x0 is consumed but not written
        bus.mem_valid       = 1'b1;
        bus.mem_destination = 5'd0;
        bus.mem_data        = 32'h1234;
        step();
        check("t3_mem_ready", 64'(obs_mem), 64'(1));
        idle_inputs();
        step();

        // 4: stall counter accumulation, clear and saturation
        bus.count_clear = 1'b1;
        step();
        bus.count_clear     = 1'b0;
        bus.alu_valid       = 1'b1;
        bus.alu_destination = 5'd11;
        bus.alu_data        = 32'h0BADF00D;
        bus.mem_valid       = 1'b1;
        bus.mem_destination = 5'd12;
        bus.mem_data        = 32'h5555AAAA;
        for (int i = 0; i < 10; i++) step();
        check("t4_stall_after_10", 64'(bus.alu_stall_count), 64'(8));
        bus.count_clear = 1'b1;
        step();
        bus.count_clear = 1'b0;
        check("t4_stall_cleared", 64'(bus.alu_stall_count), 64'(0));
        for (int i = 0; i < 25; i++) step();
        check("t4_small_saturated", 64'(sbus.alu_stall_count), 64'(15));
        idle_inputs();
        step();

        // 5: reset while a write is on the port and starvation is building
        bus.alu_valid       = 1'b1;
        bus.alu_destination = 5'd4;
        bus.alu_data        = 32'hCAFE0004;
        bus.mem_valid       = 1'b1;
        bus.mem_destination = 5'd3;
        bus.mem_data        = 32'hCAFE0003;
        step();
        step();
        check("t5_we_before_reset", 64'(bus.write_enable), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("t5_reset_write_enable", 64'(bus.write_enable), 64'(0));
        check("t5_reset_write_destination", 64'(bus.write_destination), 64'(0));
        check("t5_reset_write_data", 64'(bus.write_data), 64'(0));
        check("t5_reset_stall_count", 64'(bus.alu_stall_count), 64'(0));
        idle_inputs();
        model_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        bus.alu_valid       = 1'b1;
        bus.alu_destination = 5'd4;
        bus.alu_data        = 32'hCAFE0004;
        bus.mem_valid       = 1'b1;
        bus.mem_destination = 5'd3;
        for (int i = 0; i < 4; i++) begin
            bus.mem_data = 32'hBEE00000 + 32'(i);
            step();
            check("t5_alu_grant", 64'(obs_alu), 64'(i == 3));
        end
        idle_inputs();
        step();

        // 6: randomized traffic on both ports, requesters hold until accepted
        alu_took = 1'b1;
        mem_took = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!bus.alu_valid || alu_took) begin
                bus.alu_valid       = ($urandom_range(0, 99) < 65);
                bus.alu_destination = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
                bus.alu_data        = $urandom;
            end
            if (!bus.mem_valid || mem_took) begin
                bus.mem_valid       = ($urandom_range(0, 99) < 60);
                bus.mem_destination = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
                bus.mem_data        = $urandom;
            end
            bus.count_clear = ($urandom_range(0, 49) == 0);
            step();
        end
        idle_inputs();
        step();
        step();
        check("t6_write_count", 64'(n_dut_writes), 64'(n_exp_writes));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
